// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - Bin subtractor with start/busy/done handshake
//
// One borrow flop and three WIDTH-bit shift registers. The result takes
// WIDTH shift cycles, LSB first, and is then held in Diff/Bout until the
// next result is ready. A request is taken in IDLE and also in DONE, so
// back-to-back operations need no idle cycle between them.

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_d_sr;
  logic             r_br;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_accept;
  logic             w_last;
  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_d_sr_next;
  logic             w_unused_d0;

  // A request is only honoured when no subtraction is running; DONE counts
  // as idle so a new operand pair can launch straight out of the done cycle.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_SHIFT) && (r_count == CW'(WIDTH - 1));

  // Full-subtractor bit slice on the current LSBs.
  assign w_a       = r_a_sr[0];
  assign w_b       = r_b_sr[0];
  assign w_d       = w_a ^ w_b ^ r_br;
  assign w_br_next = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);

  // The new difference bit enters at the MSB; after WIDTH steps the
  // register holds the whole result with bit 0 at the bottom.
  assign w_d_sr_next = {w_d, r_d_sr[WIDTH-1:1]};

  // The old LSB of d_sr falls off the end on every shift and is never read.
  assign w_unused_d0 = r_d_sr[0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: SHIFT runs until the last bit, DONE lasts one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (w_accept) begin
          w_next_state = S_SHIFT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Operand load on accept, one bit-step per cycle while shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_d_sr  <= '0;
      r_br    <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_a_sr  <= A;
      r_b_sr  <= B;
      r_br    <= Bin;
      r_count <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_d_sr  <= w_d_sr_next;
      r_br    <= w_br_next;
      r_count <= r_count + 1'b1;
    end
  end

  // Result registers change only on the final bit-step (entry to DONE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_last) begin
      r_diff <= w_d_sr_next;
      r_bout <= w_br_next;
    end
  end

  assign Diff = r_diff;
  assign Bout = r_bout;

  // Status flags come straight from the state register, never from inputs.
  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor computing A − B − Bin over WIDTH clock cycles, LSB first, with a single borrow flip-flop carried between bit-steps. It is the inverse-operation, area-minimal counterpart to the team's parallel carry-look-ahead adder. It sits in the arithmetic library as a multi-cycle datapath unit with a start/busy/done handshake, for use where latency is cheaper than logic.

## Interface

Parameters:
- WIDTH, default 4, operand and result width in bits; legal range ≥ 2.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  request; sampled on a rising edge only when the unit is idle.
- A  input  WIDTH  minuend; sampled with start.
- B  input  WIDTH  subtrahend; sampled with start.
- Bin  input  1  borrow-in; sampled with start.
- Diff  output  WIDTH  result (A − B − Bin) mod 2^WIDTH; registered, held until the next result.
- Bout  output  1  borrow-out: 1 iff A < B + Bin (unsigned); registered, held with Diff.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  single-cycle pulse: Diff/Bout have just been updated.

## Operation

- FSM states: IDLE, SHIFT, DONE. Bit counter 0..WIDTH−1. Shift registers a_sr, b_sr and d_sr, each WIDTH bits. Borrow flop br.
- Idle condition: the state is IDLE or DONE.
- IDLE: if start=1, load a_sr=A, b_sr=B, br=Bin, count=0, and go to SHIFT. Otherwise stay.
- SHIFT, each edge, using a=a_sr[0], b=b_sr[0]:
  - d = a ^ b ^ br.
  - br ← (~a & b) | (~(a ^ b) & br).
  - a_sr and b_sr shift right by 1.
  - d_sr ← {d, d_sr[WIDTH−1:1]}.
  - count increments.
  - On the edge where count = WIDTH−1: Diff ← {d, d_sr[WIDTH−1:1]}, Bout ← new borrow, go to DONE.
- DONE: lasts exactly one cycle with done=1.
  - start=1 here is accepted exactly as in IDLE: operands load and the FSM goes to SHIFT (back-to-back operation).
  - Otherwise go to IDLE.
- start while in SHIFT is ignored; operands are not re-sampled.
- A, B and Bin may change freely after the sampling edge.
- Diff and Bout change only on entry to DONE or on reset.

## Timing

- Reset (asynchronous assert, any state):
  - State IDLE.
  - Diff=0, Bout=0, busy=0, done=0.
  - a_sr, b_sr, d_sr, br and count all 0.
  - An in-flight operation is aborted with no done pulse and Diff unchanged from 0.
- Reset release: start is sampled on the first rising edge with rst=0.
- start sampled at edge k:
  - busy=1 after edges k … k+WIDTH−1, i.e. WIDTH cycles.
  - After edge k+WIDTH: busy=0, done=1, Diff/Bout valid.
  - Latency is WIDTH+1 edges from the sampling edge to the done pulse.
- busy and done are never high together. done is never high for 2 consecutive cycles.
- Back-to-back throughput: one result per WIDTH+1 cycles.
- busy = (state==SHIFT); done = (state==DONE). Both are decoded from registered state, so there is no combinational path from inputs to outputs.

## Test plan

- WIDTH=4, A=7, B=3, Bin=0, one start pulse:
  - busy high for exactly 4 cycles.
  - done on the 5th edge after sampling.
  - Diff=4, Bout=0.
- A=3, B=7, Bin=0 → Diff=0xC, Bout=1.
- A=0, B=0, Bin=1 → Diff=0xF, Bout=1.
- A=15, B=15, Bin=0 → Diff=0, Bout=0.
- Handshake, with A=9, B=2, Bin=0 started:
  - Re-assert start with A=1, B=1 mid-SHIFT: the request is ignored and the result is Diff=7, Bout=0.
  - Then hold start=1 with A=5, B=6, Bin=0 during the done cycle: the next operation launches with no idle gap and yields Diff=0xF, Bout=1.
- Reset and exhaustive checks:
  - Assert rst asynchronously during the 2nd SHIFT cycle: Diff, Bout, busy and done go to 0 immediately, and no done pulse follows.
  - Then run all 512 (A,B,Bin) combinations for WIDTH=4, plus random vectors for WIDTH=8.
  - Compare every result against the {Bout,Diff} = (A − B − Bin) mod 2^(WIDTH+1) reference model.
